// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART peripheral: bus stores feed a TX FIFO drained to an AXI-stream master,
// and an RX FIFO fills from an AXI-stream slave. Optional interrupt logic: UART_MMIO_IRQ_EN.
module uart_mmio_bridge #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] bus_addr,
  input  logic [31:0]   bus_wdata,
  input  logic          bus_we,
  input  logic          bus_re,
  output logic [31:0]   bus_rdata,
  output logic [7:0]    m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  input  logic [7:0]    s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  output logic          irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;

  logic [7:0]    tx_mem_q [DEPTH];
  logic [PW-1:0] tx_wptr_q, tx_rptr_q;
  logic [CW-1:0] tx_cnt_q;
  logic [7:0]    rx_mem_q [DEPTH];
  logic [PW-1:0] rx_wptr_q, rx_rptr_q;
  logic [CW-1:0] rx_cnt_q;
  logic          tx_drop_q, rx_ovr_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   ctrl_rd;

  logic [1:0] reg_sel;
  logic       tx_full, tx_empty, rx_full, rx_avail;
  logic       data_wr, data_rd, status_rd;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       tx_drop_evt, rx_ovr_evt;

  assign reg_sel   = bus_addr[3:2];
  assign tx_full   = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty  = (tx_cnt_q == '0);
  assign rx_full   = (rx_cnt_q == CW'(DEPTH));
  assign rx_avail  = (rx_cnt_q != '0);

  assign data_wr   = bus_we && (reg_sel == RegData);
  assign data_rd   = bus_re && (reg_sel == RegData);
  assign status_rd = bus_re && (reg_sel == RegStatus);

  // A full FIFO still accepts when it is popped in the same cycle.
  assign tx_pop      = m_tvalid && m_tready;
  assign tx_push     = data_wr && (!tx_full || tx_pop);
  assign tx_drop_evt = data_wr && !tx_push;
  assign rx_pop      = data_rd && rx_avail;
  assign rx_push     = s_tvalid && (!rx_full || rx_pop);
  assign rx_ovr_evt  = s_tvalid && !rx_push;

  assign m_tvalid  = !tx_empty;
  assign m_tdata   = tx_mem_q[tx_rptr_q];
  assign s_tready  = 1'b1;
  assign bus_rdata = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{bus_addr, bus_wdata};

  always_comb begin
    rdata_d = rdata_q;
    if (bus_re) begin
      case (reg_sel)
        RegData:   rdata_d = rx_avail ? {24'b0, rx_mem_q[rx_rptr_q]} : 32'b0;
        RegStatus: rdata_d = {26'b0, rx_ovr_q, tx_drop_q, rx_full, rx_avail, tx_empty, tx_full};
        RegCtrl:   rdata_d = ctrl_rd;
        default:   rdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_drop_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wptr_q] <= bus_wdata[7:0];
        tx_wptr_q           <= tx_wptr_q + PW'(1);
      end
      if (tx_pop) tx_rptr_q <= tx_rptr_q + PW'(1);
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);

      if (rx_push) begin
        rx_mem_q[rx_wptr_q] <= s_tdata;
        rx_wptr_q           <= rx_wptr_q + PW'(1);
      end
      if (rx_pop) rx_rptr_q <= rx_rptr_q + PW'(1);
      rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

      // A fresh event in the clearing cycle keeps the sticky bit set.
      tx_drop_q <= tx_drop_evt || (tx_drop_q && !status_rd);
      rx_ovr_q  <= rx_ovr_evt || (rx_ovr_q && !status_rd);
      rdata_q   <= rdata_d;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  logic [1:0] ctrl_q;
  logic       irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (bus_we && (reg_sel == RegCtrl)) ctrl_q <= bus_wdata[1:0];
      irq_q <= (ctrl_q[0] & rx_avail) | (ctrl_q[1] & tx_empty) | rx_ovr_q;
    end
  end

  assign ctrl_rd = {30'b0, ctrl_q};
  assign irq     = irq_q;
`else
  assign ctrl_rd = '0;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: directed vector table, queue-based reference
// model checked every cycle under random traffic, plus hand-written irq and reset sequences.
module tb_uart_mmio_bridge;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_we, bus_re;
  logic [31:0]   bus_rdata;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tready;
  logic [7:0]    s_tdata;
  logic          s_tvalid, s_tready;
  logic          irq;

  uart_mmio_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: byte queues and flags updated from the register-map rules.
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          m_drop, m_ovr;
  bit   [1:0]  m_ctrl;
  logic [31:0] m_rd;
  bit          m_irq;

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_drop = 0;
    m_ovr  = 0;
    m_ctrl = 0;
    m_rd   = 0;
    m_irq  = 0;
  endtask

  task automatic model_update(input bit we, input bit re, input bit [1:0] a, input bit [7:0] wd,
                              input bit trdy, input bit sv, input bit [7:0] sd);
    int txn = txq.size();
    int rxn = rxq.size();
    bit new_drop = 0;
    bit new_ovr  = 0;
    if (re) begin
      case (a)
        2'd0: m_rd = (rxn > 0) ? {24'b0, rxq[0]} : 32'b0;
        2'd1: m_rd = {26'b0, m_ovr, m_drop, rxn == DEPTH, rxn > 0, txn == 0, txn == DEPTH};
        2'd2: m_rd = {30'b0, m_ctrl};
        default: m_rd = 32'b0;
      endcase
    end
`ifdef UART_MMIO_IRQ_EN
    m_irq = (m_ctrl[0] && rxn > 0) || (m_ctrl[1] && txn == 0) || m_ovr;
    if (we && a == 2'd2) m_ctrl = wd[1:0];
`endif
    if (trdy && txn > 0) void'(txq.pop_front());
    if (we && a == 2'd0) begin
      if (txq.size() < DEPTH) txq.push_back(wd);
      else new_drop = 1;
    end
    if (re && a == 2'd0 && rxn > 0) void'(rxq.pop_front());
    if (sv) begin
      if (rxq.size() < DEPTH) rxq.push_back(sd);
      else new_ovr = 1;
    end
    m_drop = new_drop || (m_drop && !(re && a == 2'd1));
    m_ovr  = new_ovr || (m_ovr && !(re && a == 2'd1));
  endtask

  // One bus cycle: drive, advance the model, clock, then compare all outputs.
  task automatic step(input bit we, input bit re, input bit [1:0] a, input bit [7:0] wd,
                      input bit trdy, input bit sv, input bit [7:0] sd);
    bus_we    = we;
    bus_re    = re;
    bus_addr  = {a, 2'($urandom_range(3))};
    bus_wdata = {24'($urandom), wd};
    m_tready  = trdy;
    s_tvalid  = sv;
    s_tdata   = sd;
    model_update(we, re, a, wd, trdy, sv, sd);
    @(posedge clk);
    #1;
    chk("model_rdata", bus_rdata, m_rd);
    chk("model_tvalid", 32'(m_tvalid), 32'(txq.size() > 0));
    if (txq.size() > 0) chk("model_tdata", 32'(m_tdata), 32'(txq[0]));
    chk("model_irq", 32'(irq), 32'(m_irq));
    chk("s_tready", 32'(s_tready), 32'd1);
  endtask

  typedef struct {
    bit        we, re;
    bit [1:0]  a;
    bit [7:0]  wd;
    bit        trdy, sv;
    bit [7:0]  sd;
    bit        ck_rd;
    bit [31:0] rd;
    bit        ck_tx, tv;
    bit [7:0]  td;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int we, input int re, input int a, input int wd, input int trdy,
                     input int sv, input int sd, input int ck_rd, input int rd, input int ck_tx,
                     input int tv, input int td);
    vec_t v;
    v.we = we[0];  v.re = re[0];  v.a = a[1:0];  v.wd = wd[7:0];
    v.trdy = trdy[0];  v.sv = sv[0];  v.sd = sd[7:0];
    v.ck_rd = ck_rd[0];  v.rd = rd;  v.ck_tx = ck_tx[0];  v.tv = tv[0];  v.td = td[7:0];
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;  bus_we = 0;  bus_re = 0;  bus_addr = '0;  bus_wdata = '0;
    m_tready = 0;  s_tvalid = 0;  s_tdata = '0;
    model_reset();
    #12;
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_tdata", 32'(m_tdata), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_s_tready", 32'(s_tready), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // we re a wd trdy sv sd | ck_rd rd | ck_tx tv td
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h02, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 'h41 + i, 0, 0, 0, 0, 0, 1, 1, 'h41);
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h00, 1, 1, 'h41);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 'h42);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 'h43);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    // TX overflow: ninth byte dropped
    for (int i = 0; i < 9; i++) add(1, 0, 0, i, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h11, 1, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, (i < 7) ? 1 : 0, i + 1);
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h02, 1, 0, 0);
    // RX overrun with one TX byte parked so tx_empty is clear
    add(1, 0, 0, 'h5A, 0, 0, 0, 0, 0, 1, 1, 'h5A);
    for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 0, 1, 'h10 + i, 0, 0, 1, 1, 'h5A);
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h2C, 1, 1, 'h5A);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 0, 0, 0, 1, 'h10 + i, 1, 1, 'h5A);
    add(0, 1, 0, 0, 1, 0, 0, 1, 'h00, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h02, 1, 0, 0);
    // Full RX: read and push in the same cycle
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 1, 'h20 + i, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 'h99, 1, 'h20, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h0E, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 0, 0, 0, 1, 'h21 + i, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 'h99, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h02, 0, 0, 0);
    // Simultaneous write and read: read sees pre-write state
    add(1, 1, 0, 'h77, 0, 0, 0, 1, 'h00, 1, 1, 'h77);
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h00, 1, 1, 'h77);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    // Address 3: writes ignored, reads 0
    add(1, 0, 3, 'hAB, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 3, 0, 0, 0, 0, 1, 'h00, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1, 'h02, 1, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd, vecs[i].trdy, vecs[i].sv, vecs[i].sd);
      if (vecs[i].ck_rd) chk($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].rd);
      if (vecs[i].ck_tx) begin
        chk($sformatf("vec%0d_tvalid", i), 32'(m_tvalid), 32'(vecs[i].tv));
        if (vecs[i].tv) chk($sformatf("vec%0d_tdata", i), 32'(m_tdata), 32'(vecs[i].td));
      end
    end

`ifdef UART_MMIO_IRQ_EN
    step(1, 0, 2, 8'h01, 0, 0, 8'h00);
    chk("irq_before_push", 32'(irq), 32'h0);
    step(0, 0, 0, 8'h00, 0, 1, 8'h55);
    chk("irq_push_edge", 32'(irq), 32'h0);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00);
    chk("irq_rise", 32'(irq), 32'h1);
    step(0, 1, 0, 8'h00, 0, 0, 8'h00);
    chk("irq_rd_data", bus_rdata, 32'h55);
    chk("irq_read_edge", 32'(irq), 32'h1);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00);
    chk("irq_fall", 32'(irq), 32'h0);
    step(1, 1, 2, 8'h02, 0, 0, 8'h00);
    chk("ctrl_pre_write", bus_rdata, 32'h1);
    step(0, 1, 2, 8'h00, 0, 0, 8'h00);
    chk("ctrl_readback", bus_rdata, 32'h2);
    step(1, 0, 2, 8'h00, 0, 0, 8'h00);
`else
    step(1, 0, 2, 8'h03, 0, 0, 8'h00);
    step(0, 1, 2, 8'h00, 0, 0, 8'h00);
    chk("ctrl_reads_zero", bus_rdata, 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      int ph = (i / 300) % 4;
      bit we = ($urandom_range(9) < ((ph == 1) ? 6 : 3));
      bit re = ($urandom_range(9) < ((ph == 2) ? 1 : 4));
      bit trdy = ($urandom_range(9) < ((ph == 1) ? 1 : 6));
      bit sv = ($urandom_range(9) < ((ph == 2) ? 7 : 3));
      bit [1:0] a = ($urandom_range(9) < 6) ? 2'd0 : 2'($urandom_range(3));
      step(we, re, a, 8'($urandom), trdy, sv, 8'($urandom));
    end

    // Reset in the middle of a drain
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'hC0 + 8'(i), 0, 0, 8'h00);
`ifdef UART_MMIO_IRQ_EN
    step(1, 0, 2, 8'h01, 0, 1, 8'h66);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 0, 8'h00);
    chk("irq_before_reset", 32'(irq), 32'h1);
`endif
    step(0, 0, 0, 8'h00, 1, 0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_tvalid", 32'(m_tvalid), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_rdata", bus_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 1, 8'h00, 1, 0, 8'h00);
    chk("post_reset_status", bus_rdata, 32'h02);
    step(0, 1, 0, 8'h00, 1, 0, 8'h00);
    chk("post_reset_data", bus_rdata, 32'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
